// File: rtl/fft4_stream_ctrl.sv
// fft4_stream_ctrl: collects four streamed complex samples into a frame, launches the frame on the
// parallel 4-point FFT core, captures the four bins and streams them out as X0..X3.
// Latency: 4th sample accept to first bin valid is CORE_LAT+2 cycles; bins drain one per m_ready cycle.
// Backpressure: s_ready drops while a frame is in flight; bins hold on m_valid && !m_ready.
// Ports: s_* sample input handshake; core_in_* / core_out_* packed {x3,x2,x1,x0} / {X3,X2,X1,X0}
//        core connection; m_* bin output handshake with index and last flag; busy, frame_done status.
// Option: define FFT4_OVERLAP_EN to fill the next frame while the current one drains.
module fft4_stream_ctrl #(
  parameter int DW       = 32,
  parameter int OW       = 35,
  parameter int CORE_LAT = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            s_valid,
  output logic            s_ready,
  input  logic [DW-1:0]   s_re,
  input  logic [DW-1:0]   s_im,
  output logic [4*DW-1:0] core_in_re,
  output logic [4*DW-1:0] core_in_im,
  input  logic [4*OW-1:0] core_out_re,
  input  logic [4*OW-1:0] core_out_im,
  output logic            m_valid,
  input  logic            m_ready,
  output logic [OW-1:0]   m_re,
  output logic [OW-1:0]   m_im,
  output logic [1:0]      m_idx,
  output logic            m_last,
  output logic            busy,
  output logic            frame_done
);

  localparam int RCW = (CORE_LAT > 0) ? $clog2(CORE_LAT + 1) : 1;

  typedef enum logic [1:0] {FILL, RUN, DRAIN} state_t;

  state_t         state;
  logic [1:0]     wr_cnt;
  logic           full;
  logic [RCW-1:0] run_cnt;
  logic [1:0]     rd_cnt;

  logic [DW-1:0]  ibuf_re [4];
  logic [DW-1:0]  ibuf_im [4];
  logic [DW-1:0]  launch_re [4];
  logic [DW-1:0]  launch_im [4];
  logic [OW-1:0]  obuf_re [4];
  logic [OW-1:0]  obuf_im [4];

  // ibuf contents including a sample accepted this cycle, so the 4th sample
  // can go straight into the launch registers without an extra cycle.
  logic [DW-1:0]  nxt_re [4];
  logic [DW-1:0]  nxt_im [4];

  logic acc;
  logic full_now;

  assign acc      = s_valid && s_ready;
  assign full_now = full || (acc && (wr_cnt == 2'd3));

`ifdef FFT4_OVERLAP_EN
  assign s_ready = ((state == FILL) || (state == DRAIN)) && !full;
`else
  assign s_ready = (state == FILL) && !full;
`endif

  assign m_valid    = (state == DRAIN);
  assign m_idx      = rd_cnt;
  assign m_re       = obuf_re[rd_cnt];
  assign m_im       = obuf_im[rd_cnt];
  assign m_last     = m_valid && (rd_cnt == 2'd3);
  assign frame_done = m_last && m_ready;
  assign busy       = (state != FILL) || (wr_cnt != 2'd0) || full;

  assign core_in_re = {launch_re[3], launch_re[2], launch_re[1], launch_re[0]};
  assign core_in_im = {launch_im[3], launch_im[2], launch_im[1], launch_im[0]};

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      nxt_re[i] = ibuf_re[i];
      nxt_im[i] = ibuf_im[i];
    end
    if (acc) begin
      nxt_re[wr_cnt] = s_re;
      nxt_im[wr_cnt] = s_im;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= FILL;
      wr_cnt  <= 2'd0;
      full    <= 1'b0;
      run_cnt <= '0;
      rd_cnt  <= 2'd0;
      for (int i = 0; i < 4; i++) begin
        ibuf_re[i]   <= '0;
        ibuf_im[i]   <= '0;
        launch_re[i] <= '0;
        launch_im[i] <= '0;
        obuf_re[i]   <= '0;
        obuf_im[i]   <= '0;
      end
    end else begin
      ibuf_re <= nxt_re;
      ibuf_im <= nxt_im;
      if (acc) begin
        wr_cnt <= wr_cnt + 2'd1;
        if (wr_cnt == 2'd3) full <= 1'b1;
      end

      // Later assignments to wr_cnt/full below override the accept bookkeeping
      // when the frame is handed to the launch registers in the same cycle.
      case (state)
        FILL: begin
          if (full_now) begin
            launch_re <= nxt_re;
            launch_im <= nxt_im;
            wr_cnt    <= 2'd0;
            full      <= 1'b0;
            run_cnt   <= '0;
            state     <= RUN;
          end
        end
        RUN: begin
          // launch is untouched here so the core sees a stable frame.
          if (run_cnt == RCW'(CORE_LAT)) begin
            for (int k = 0; k < 4; k++) begin
              obuf_re[k] <= core_out_re[k*OW +: OW];
              obuf_im[k] <= core_out_im[k*OW +: OW];
            end
            rd_cnt <= 2'd0;
            state  <= DRAIN;
          end else begin
            run_cnt <= run_cnt + RCW'(1);
          end
        end
        DRAIN: begin
          if (m_ready) begin
            rd_cnt <= rd_cnt + 2'd1;
            if (rd_cnt == 2'd3) begin
`ifdef FFT4_OVERLAP_EN
              if (full_now) begin
                launch_re <= nxt_re;
                launch_im <= nxt_im;
                wr_cnt    <= 2'd0;
                full      <= 1'b0;
                run_cnt   <= '0;
                state     <= RUN;
              end else begin
                state <= FILL;
              end
`else
              state <= FILL;
`endif
            end
          end
        end
        default: state <= FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_fft4_stream_ctrl.sv
// tb_fft4_stream_ctrl: directed vectors through fft4_stream_ctrl with a behavioural
// 4-point DIT FFT core (CORE_LAT register stages) attached to its core ports.
// Expected bins are hand-computed constants in the vector table.
module tb_fft4_stream_ctrl;

  localparam int DW       = 32;
  localparam int OW       = 35;
  localparam int CORE_LAT = 2;
`ifdef FFT4_OVERLAP_EN
  localparam int PERIOD = 4 + CORE_LAT + 1;
`else
  localparam int PERIOD = 4 + (CORE_LAT + 1) + 4;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic            s_valid;
  logic            s_ready;
  logic [DW-1:0]   s_re;
  logic [DW-1:0]   s_im;
  logic [4*DW-1:0] core_in_re;
  logic [4*DW-1:0] core_in_im;
  logic [4*OW-1:0] core_out_re;
  logic [4*OW-1:0] core_out_im;
  logic            m_valid;
  logic            m_ready;
  logic [OW-1:0]   m_re;
  logic [OW-1:0]   m_im;
  logic [1:0]      m_idx;
  logic            m_last;
  logic            busy;
  logic            frame_done;

  always #5 clk = ~clk;

  fft4_stream_ctrl #(.DW(DW), .OW(OW), .CORE_LAT(CORE_LAT)) dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready), .s_re(s_re), .s_im(s_im),
    .core_in_re(core_in_re), .core_in_im(core_in_im),
    .core_out_re(core_out_re), .core_out_im(core_out_im),
    .m_valid(m_valid), .m_ready(m_ready), .m_re(m_re), .m_im(m_im),
    .m_idx(m_idx), .m_last(m_last), .busy(busy), .frame_done(frame_done)
  );

  // ---------------- behavioural FFT core ----------------
  logic signed [OW-1:0] xr [4], xi [4], fr [4], fi [4];
  logic signed [OW-1:0] s1r [4], s1i [4], s2r [4], s2i [4];

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      xr[i] = {{(OW-DW){core_in_re[i*DW+DW-1]}}, core_in_re[i*DW +: DW]};
      xi[i] = {{(OW-DW){core_in_im[i*DW+DW-1]}}, core_in_im[i*DW +: DW]};
    end
    fr[0] = xr[0] + xr[1] + xr[2] + xr[3];
    fi[0] = xi[0] + xi[1] + xi[2] + xi[3];
    fr[1] = xr[0] + xi[1] - xr[2] - xi[3];
    fi[1] = xi[0] - xr[1] - xi[2] + xr[3];
    fr[2] = xr[0] - xr[1] + xr[2] - xr[3];
    fi[2] = xi[0] - xi[1] + xi[2] - xi[3];
    fr[3] = xr[0] - xi[1] - xr[2] + xi[3];
    fi[3] = xi[0] + xr[1] - xi[2] - xr[3];
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        s1r[i] <= '0; s1i[i] <= '0; s2r[i] <= '0; s2i[i] <= '0;
      end
    end else begin
      s1r <= fr; s1i <= fi; s2r <= s1r; s2i <= s1i;
    end
  end

  assign core_out_re = {s2r[3], s2r[2], s2r[1], s2r[0]};
  assign core_out_im = {s2i[3], s2i[2], s2i[1], s2i[0]};

  // ---------------- checking ----------------
  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input longint act, input longint exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    string name;
    int    xr [4];
    int    xi [4];
    int    er [4];
    int    ei [4];
  } vec_t;

  vec_t vecs [7];

  task automatic push(input int re, input int im);
    int t = 0;
    s_valid = 1'b1;
    s_re    = DW'(re);
    s_im    = DW'(im);
    while (!s_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!s_ready) check("push timeout s_ready", s_ready, 1);
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  // Starts at a negedge where bin 0 is expected valid; pat bit c is m_ready in drain cycle c.
  task automatic drain_frame(input int v, input logic [7:0] pat, input int n);
    int k = 0;
    for (int c = 0; c < n && k < 4; c++) begin
      m_ready = pat[c];
      #1;
      check($sformatf("%s m_valid c%0d", vecs[v].name, c), m_valid, 1);
      check($sformatf("%s m_idx c%0d", vecs[v].name, c), m_idx, k);
      check($sformatf("%s m_re k%0d", vecs[v].name, k), $signed(m_re), vecs[v].er[k]);
      check($sformatf("%s m_im k%0d", vecs[v].name, k), $signed(m_im), vecs[v].ei[k]);
      check($sformatf("%s m_last k%0d", vecs[v].name, k), m_last, (k == 3) ? 1 : 0);
      check($sformatf("%s frame_done c%0d", vecs[v].name, c), frame_done,
            (pat[c] && k == 3) ? 1 : 0);
      if (pat[c]) k++;
      @(negedge clk);
    end
    check($sformatf("%s bins drained", vecs[v].name), k, 4);
    #1;
    check($sformatf("%s m_valid after frame", vecs[v].name), m_valid, 0);
    check($sformatf("%s frame_done after frame", vecs[v].name), frame_done, 0);
    m_ready = 1'b0;
  endtask

  task automatic run_frame(input int v, input logic [7:0] pat, input int n);
    int lat;
    m_ready = 1'b0;
    for (int i = 0; i < 4; i++) push(vecs[v].xr[i], vecs[v].xi[i]);
    // First cycle after the 4th accept: core running, input closed.
    check($sformatf("%s s_ready in RUN", vecs[v].name), s_ready, 0);
    check($sformatf("%s busy in RUN", vecs[v].name), busy, 1);
    lat = 1;
    while (!m_valid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    check($sformatf("%s latency", vecs[v].name), lat, CORE_LAT + 2);
    drain_frame(v, pat, n);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int starts [$];
    logic sr_hist [80];
    logic mv_hist [80];
    int bad_bins, ready_in_frame, valid_in_frame, overlap_viol;

    vecs[0] = '{name:"impulse",  xr:'{1,0,0,0},  xi:'{0,0,0,0},
                er:'{1,1,1,1},    ei:'{0,0,0,0}};
    vecs[1] = '{name:"dc",       xr:'{5,5,5,5},  xi:'{0,0,0,0},
                er:'{20,0,0,0},   ei:'{0,0,0,0}};
    vecs[2] = '{name:"delayed",  xr:'{0,1,0,0},  xi:'{0,0,0,0},
                er:'{1,0,-1,0},   ei:'{0,-1,0,1}};
    vecs[3] = '{name:"ramp",     xr:'{1,2,3,4},  xi:'{0,0,0,0},
                er:'{10,-2,-2,-2}, ei:'{0,2,0,-2}};
    vecs[4] = '{name:"imag",     xr:'{0,0,0,0},  xi:'{0,1,0,0},
                er:'{0,1,0,-1},   ei:'{1,0,-1,0}};
    vecs[5] = '{name:"negimp",   xr:'{-3,0,0,0}, xi:'{1,0,0,0},
                er:'{-3,-3,-3,-3}, ei:'{1,1,1,1}};
    vecs[6] = '{name:"post_rst", xr:'{2,2,2,2},  xi:'{0,0,0,0},
                er:'{8,0,0,0},    ei:'{0,0,0,0}};

    rst = 1'b1; s_valid = 1'b0; s_re = '0; s_im = '0; m_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("reset s_ready", s_ready, 1);
    check("reset m_valid", m_valid, 0);
    check("reset busy", busy, 0);
    check("reset m_idx", m_idx, 0);
    check("reset core_in zero", (core_in_re == '0) && (core_in_im == '0), 1);
    rst = 1'b0;
    @(negedge clk);

    for (int v = 0; v < 6; v++) run_frame(v, 8'hFF, 4);

    // Backpressure: m_ready 1,0,0,1,0,1,1 across the drain.
    run_frame(3, 8'b0110_1001, 7);

    // Reset mid-frame: two samples in, then reset.
    push(3, 0);
    push(7, 0);
    check("midframe busy", busy, 1);
    rst = 1'b1;
    #1;
    check("midrst s_ready", s_ready, 1);
    check("midrst busy", busy, 0);
    check("midrst m_valid", m_valid, 0);
    check("midrst m_re", $signed(m_re), 0);
    check("midrst m_last", m_last, 0);
    check("midrst frame_done", frame_done, 0);
    check("midrst core_in zero", (core_in_re == '0) && (core_in_im == '0), 1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_frame(6, 8'hFF, 4);

    // Back-to-back frames with continuous valid/ready; every frame is DC of (1,0).
    s_valid = 1'b1; s_re = DW'(1); s_im = '0; m_ready = 1'b1;
    bad_bins = 0; overlap_viol = 0;
    for (int c = 0; c < 80; c++) begin
      #1;
      sr_hist[c] = s_ready;
      mv_hist[c] = m_valid;
      if (m_valid && m_idx == 2'd0) starts.push_back(c);
      if (m_valid && ($signed(m_re) != ((m_idx == 2'd0) ? 4 : 0) || m_im != '0)) bad_bins++;
      if (m_valid && s_ready) overlap_viol++;
      @(negedge clk);
    end
    s_valid = 1'b0;
    m_ready = 1'b0;
    check("b2b bin values", bad_bins, 0);
`ifdef FFT4_OVERLAP_EN
    check("b2b fill during drain", overlap_viol, 4 * (starts.size() > 0 ? starts.size() - 1 : 0));
`else
    check("b2b s_ready low in drain", overlap_viol, 0);
`endif
    check("b2b burst count>=3", starts.size() >= 3, 1);
    if (starts.size() >= 3) begin
      check("b2b period 1", starts[1] - starts[0], PERIOD);
      check("b2b period 2", starts[2] - starts[1], PERIOD);
      ready_in_frame = 0;
      valid_in_frame = 0;
      for (int c = starts[0]; c < starts[1]; c++) begin
        if (sr_hist[c]) ready_in_frame++;
        if (mv_hist[c]) valid_in_frame++;
      end
      check("b2b ready cycles per frame", ready_in_frame, 4);
      check("b2b burst length", valid_in_frame, 4);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fft4_stream_ctrl.md
# fft4_stream_ctrl

Sequencing controller for the pipelined 4-point DIT FFT core. It accepts a stream of complex samples over a valid/ready handshake and collects them into 4-sample frames. For each frame it drives the core's parallel inputs, waits out the core's pipeline latency and captures the four bins. It then streams the bins out in natural order (X0..X3) over a second valid/ready handshake, so streaming sources and sinks can use the parallel FFT core.

## Interface
- DW, 32, input sample component width (signed)
- OW, 35, output bin component width (signed, DW+3)
- CORE_LAT, 2, core register stages from input change to valid output
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset; also drives core rst
- s_valid  in  1  input sample valid
- s_ready  out  1  controller can accept a sample
- s_re, s_im  in  DW  input sample, signed two's complement
- core_in_re, core_in_im  out  4*DW  packed {x3,x2,x1,x0} to core in4..in1 (re/im)
- core_out_re, core_out_im  in  4*OW  packed {X3,X2,X1,X0} from core out4..out1
- m_valid  out  1  output bin valid
- m_ready  in  1  sink accepts bin
- m_re, m_im  out  OW  output bin
- m_idx  out  2  bin index k of current m_re/m_im
- m_last  out  1  high with k=3
- busy  out  1  state != FILL or input buffer non-empty
- frame_done  out  1  one-cycle pulse on the handshake of bin 3

## Operation
- Storage:
  - ibuf: 4 complex entries, written at wr_cnt (2b) plus full flag.
  - launch: 4 complex registers driving core_in.
  - obuf: 4 complex OW entries, read pointer rd_cnt.
- FSM states FILL, RUN, DRAIN; reset state FILL.
- FILL:
  - Sample accepted on s_valid&&s_ready, written to ibuf[wr_cnt], wr_cnt++.
  - On the 4th accept, or on entering FILL with ibuf full: copy ibuf to launch, clear wr_cnt/full, go to RUN.
- RUN:
  - run_cnt counts CORE_LAT+1 cycles; launch registers are held constant throughout.
  - On the last RUN cycle, core_out is captured into obuf, rd_cnt=0, and the FSM goes to DRAIN.
- DRAIN:
  - m_valid=1; m_re/m_im=obuf[rd_cnt]; m_idx=rd_cnt.
  - On m_valid&&m_ready, rd_cnt++.
  - On the handshake with rd_cnt=3: frame_done pulses; go to RUN (launching ibuf) if ibuf is full, else go to FILL.
- No arithmetic is performed in this block. Bins pass through unmodified at OW width, and inputs are not extended (the core grows widths itself).
- s_ready:
  - FILL: 1 while ibuf is not full.
  - RUN: 0.
  - DRAIN: see Configuration.
- Outputs stay stable while m_valid&&!m_ready (AXI-style hold). s_valid may drop at any time without penalty.
- Reset mid-frame: async clear of FSM, counters, ibuf full flag, launch, obuf. Any partial frame is discarded, and no output appears until 4 new samples are accepted.

## Timing
- Reset values:
  - s_ready=1, m_valid=0, m_re/m_im=0, m_idx=0, m_last=0, busy=0, frame_done=0.
  - core_in_* = 0.
- Accept of the 4th sample at the end of cycle C0 gives:
  - RUN in C1..C(1+CORE_LAT).
  - First m_valid in C(2+CORE_LAT), i.e. C4 at default.
- With m_ready held high, bins occupy 4 consecutive cycles.
- Non-overlapped frame period with continuous input/output: 4 + (CORE_LAT+1) + 4 = 11 cycles.
- With overlap: 4 + CORE_LAT + 1 = 7 cycles.

## Configuration
- FFT4_OVERLAP_EN defined:
  - s_ready=!full also in DRAIN, so the next frame fills ibuf while the current frame drains.
  - Drain completion with full ibuf goes directly to RUN, with no idle cycle.
- Undefined:
  - s_ready=0 in DRAIN; the next frame is accepted only after FILL is re-entered.
  - The DRAIN→RUN path is unreachable.

## Test plan
- Impulse: samples (1,0),(0,0),(0,0),(0,0), m_ready=1 -> bins k=0..3 all (1,0); first m_valid exactly 4 cycles after the 4th accept; m_last on k=3; frame_done one pulse.
- DC: four samples (5,0) -> X0=(20,0), X1=X2=X3=(0,0).
- Delayed impulse: (0,0),(1,0),(0,0),(0,0) -> X0=(1,0), X1=(0,-1), X2=(-1,0), X3=(0,1).
- Backpressure: m_ready toggled 1,0,0,1,0,1,1 during drain -> each bin held stable until its handshake; order 0..3; no bin dropped or duplicated.
- Reset mid-frame: accept 2 samples, assert rst 1 cycle -> all outputs at reset values; next 4 samples (2,0)x4 yield X0=(8,0) and zeros only.
- Back-to-back frames, continuous valid/ready:
  - With FFT4_OVERLAP_EN: m_valid bursts of 4 every 7 cycles.
  - Without FFT4_OVERLAP_EN: s_ready=0 throughout RUN and DRAIN, with a period of 11 cycles.
